// File: rtl/car_pkg.sv
// Shared constants and FSM encoding for the ultrasonic ranging path.
// The trigger generator reuses CLK_PER_US from here.
package car_pkg;

    localparam int unsigned CLK_PER_US = 125;
    localparam int unsigned MAX_US     = 38000;
    localparam int unsigned ARM_TO_US  = 2000;
    localparam int unsigned K_MM       = 11239;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROD_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        MEAS     = 3'd2,
        CALC     = 3'd3,
        DONE     = 3'd4,
        WAIT_LOW = 3'd5
    } state_e;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser for the asynchronous echo input, plus one extra
// stage so rising/falling edges can be decoded in the clk domain.
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic echo_meta;
    logic echo_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/echo_meas.sv
// Measures the ranger echo high time in microseconds after each trigger and
// scales it to millimetres; one valid or timeout strobe per trigger.
module echo_meas
    import car_pkg::*;
#(
    parameter int unsigned CLK_PER_US = car_pkg::CLK_PER_US,
    parameter int unsigned MAX_US     = car_pkg::MAX_US,
    parameter int unsigned ARM_TO_US  = car_pkg::ARM_TO_US,
    parameter int unsigned K_MM       = car_pkg::K_MM
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trig,
    input  logic              echo,
    output logic [DATA_W-1:0] echo_us,
    output logic [DATA_W-1:0] dist_mm,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned US_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    state_e            state_q;
    state_e            state_next;
    logic [US_W-1:0]   us_cnt_q;
    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_next;
    logic [PROD_W-1:0] product_q;
    logic              trig_d;
    logic              trig_fall;
    logic              tick;
    logic              echo_s;
    logic              rise;
    logic              fall;
    logic              load_result;
    logic              timeout_set;

    echo_sync u_echo_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .echo   (echo),
        .echo_s (echo_s),
        .rise   (rise),
        .fall   (fall)
    );

    assign trig_fall = ~trig & trig_d;
    assign tick      = (us_cnt_q == US_W'(CLK_PER_US - 1));

    // cnt_q is the arm wait counter in ARM and the echo width in MEAS/CALC
    always_comb begin
        state_next  = state_q;
        cnt_next    = cnt_q;
        load_result = 1'b0;
        timeout_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_fall) begin
                    state_next = ARM;
                    cnt_next   = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_next = MEAS;
                    cnt_next   = '0;
                end else if (tick) begin
                    cnt_next = cnt_q + DATA_W'(1);
                    if (cnt_q == DATA_W'(ARM_TO_US - 1)) begin
                        state_next  = IDLE;
                        timeout_set = 1'b1;
                    end
                end
            end
            MEAS: begin
                cnt_next = cnt_q + DATA_W'(tick);
                if (fall) begin
                    state_next = CALC;
                end else if (tick && (cnt_q == DATA_W'(MAX_US - 1))) begin
                    state_next  = WAIT_LOW;
                    timeout_set = 1'b1;
                end
            end
            CALC: begin
                state_next  = DONE;
                load_result = 1'b1;
            end
            DONE: begin
                state_next = IDLE;
            end
            WAIT_LOW: begin
                if (!echo_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_d  <= 1'b0;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            trig_d  <= trig;
        end
    end

    // Prescaler restarts on every state change so each state counts whole us
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_cnt_q <= '0;
        end else if ((state_next != state_q) || tick) begin
            us_cnt_q <= '0;
        end else begin
            us_cnt_q <= us_cnt_q + US_W'(1);
        end
    end

    // Result registers load in CALC so they are visible alongside valid in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_us   <= '0;
            product_q <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid   <= load_result;
            timeout <= timeout_set;
            busy    <= (state_next != IDLE);
            if (load_result) begin
                echo_us   <= cnt_q;
                product_q <= PROD_W'(cnt_q) * PROD_W'(K_MM);
            end
        end
    end

    assign dist_mm = DATA_W'(product_q >> DATA_W);

endmodule

// File: tb/tb_echo_meas.sv
// Randomised and directed bench for echo_meas against a per-shot
// behavioural outcome model, using shortened timing parameters.
module tb_echo_meas;
    import car_pkg::*;

    localparam int unsigned T_CLK = 2;
    localparam int unsigned T_MAX = 6000;
    localparam int unsigned T_ARM = 400;
    localparam int ARM_CYC = int'(T_CLK * T_ARM);
    localparam int MAX_CYC = int'(T_CLK * T_MAX);

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        trig  = 1'b0;
    logic        echo  = 1'b0;
    logic [15:0] echo_us;
    logic [15:0] dist_mm;
    logic        valid;
    logic        timeout;
    logic        busy;

    echo_meas #(
        .CLK_PER_US (T_CLK),
        .MAX_US     (T_MAX),
        .ARM_TO_US  (T_ARM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trig    (trig),
        .echo    (echo),
        .echo_us (echo_us),
        .dist_mm (dist_mm),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected behaviour of the current shot, in absolute cycle numbers
    int busy_from    = 1;
    int busy_to      = 0;
    int strobe_cyc   = -1;
    bit strobe_valid = 1'b0;
    int exp_width    = 0;
    int pin_cyc      = -1;
    int pin_kind     = 0;
    int pin_us       = 0;
    int pin_mm       = 0;

    int checks   = 0;
    int failures = 0;
    int m_us     = 0;
    int m_mm     = 0;

    function automatic int dist_of(input int us);
        longint p;
        p = longint'(us) * longint'(K_MM);
        return int'(p / 65536);
    endfunction

    always @(negedge clk) begin : cmp
        logic ev, et, eb;
        if (!rst_n) begin
            m_us = 0;
            m_mm = 0;
            ev   = 1'b0;
            et   = 1'b0;
            eb   = 1'b0;
        end else begin
            ev = (cyc == strobe_cyc) && strobe_valid;
            et = (cyc == strobe_cyc) && !strobe_valid;
            eb = (cyc >= busy_from) && (cyc <= busy_to);
            if (ev) begin
                m_us = exp_width;
                m_mm = dist_of(exp_width);
            end
        end
        checks++;
        if ({valid, timeout, busy, echo_us, dist_mm} !== {ev, et, eb, 16'(m_us), 16'(m_mm)}) begin
            failures++;
            $display("FAIL outputs cyc=%0d got v=%b t=%b b=%b us=%0d mm=%0d want v=%b t=%b b=%b us=%0d mm=%0d",
                     cyc, valid, timeout, busy, echo_us, dist_mm, ev, et, eb, m_us, m_mm);
        end
        if (rst_n && (cyc == pin_cyc)) begin
            checks++;
            if (!((pin_kind == 1 ? (valid && !timeout) : (timeout && !valid)) &&
                  echo_us == 16'(pin_us) && dist_mm == 16'(pin_mm))) begin
                failures++;
                $display("FAIL pin kind=%0d cyc=%0d got v=%b t=%b us=%0d mm=%0d want us=%0d mm=%0d",
                         pin_kind, cyc, valid, timeout, echo_us, dist_mm, pin_us, pin_mm);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One trigger period; pk/poff/pus/pmm pin a literal expectation
    // (pk=1 valid at e1+poff, pk=2 timeout at f0+poff).
    task automatic shot(input bit pre_high, input int arm_dly, input int high, input bit retrig,
                        input int pk, input int poff, input int pus, input int pmm);
        int  f0, a, e0, e1, sv, bto, last, h1;
        bit  is_valid, arm_to;
        wait_cyc(3);
        if (pre_high) begin
            echo = 1'b1;
            wait_cyc(4);
        end
        trig = 1'b1;
        wait_cyc(3);
        f0 = cyc;
        a  = f0 + 1;
        e0 = pre_high ? f0 + 6 + arm_dly : f0 + arm_dly;
        e1 = e0 + high;
        arm_to = (e0 + 2 > a + ARM_CYC - 1);
        if (arm_to) begin
            sv = a + ARM_CYC;      is_valid = 1'b0; bto = sv - 1;
        end else if (high > MAX_CYC) begin
            sv = e0 + 3 + MAX_CYC; is_valid = 1'b0; bto = e1 + 2;
        end else begin
            sv = e1 + 4;           is_valid = 1'b1; bto = sv;
        end
        busy_from    = a;
        busy_to      = bto;
        strobe_cyc   = sv;
        strobe_valid = is_valid;
        exp_width    = high / int'(T_CLK);
        pin_kind     = pk;
        pin_us       = pus;
        pin_mm       = pmm;
        pin_cyc      = (pk == 1) ? e1 + poff : ((pk == 2) ? f0 + poff : -1);
        trig = 1'b0;
        if (pre_high) begin
            wait_cyc(3);
            echo = 1'b0;
            wait_cyc(3 + arm_dly);
        end else begin
            wait_cyc(arm_dly);
        end
        echo = 1'b1;
        if (retrig && !arm_to) begin
            h1 = high / 2;
            wait_cyc(h1);
            trig = 1'b1;
            wait_cyc(2);
            trig = 1'b0;
            wait_cyc(high - h1 - 2);
        end else begin
            wait_cyc(high);
        end
        echo = 1'b0;
        last = (sv > e1 + 4) ? sv : e1 + 4;
        wait_cyc(last - cyc + 3);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);

        // reset in the middle of a measurement: no strobe, outputs cleared
        trig = 1'b1;
        wait_cyc(3);
        busy_from = cyc + 1;
        busy_to   = 1 << 30;
        trig = 1'b0;
        wait_cyc(20);
        echo = 1'b1;
        wait_cyc(200);
        busy_from = 1;
        busy_to   = 0;
        rst_n = 1'b0;
        wait_cyc(2);
        echo = 1'b0;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(30);

        // nominal 1000 us, 1 m target, missing echo, stuck echo
        shot(1'b0, 600, 1000 * T_CLK, 1'b0, 1, 4, 1000, 171);
        shot(1'b0, 40, 5831 * T_CLK, 1'b0, 1, 4, 5831, 999);
        shot(1'b0, ARM_CYC + 20, 20, 1'b0, 2, 801, 5831, 999);
        shot(1'b0, 10, MAX_CYC + 1000, 1'b0, 2, 12013, 5831, 999);
        // fall on the same tick the width reaches the limit
        shot(1'b0, 10, MAX_CYC, 1'b0, 1, 4, 6000, 1028);
        // rise on the last arm tick wins; one cycle later times out
        shot(1'b0, ARM_CYC - 2, 40, 1'b0, 0, 0, 0, 0);
        shot(1'b0, ARM_CYC - 1, 40, 1'b0, 0, 0, 0, 0);
        // echo already high at trigger, then re-trigger during measurement
        shot(1'b1, 100, 400, 1'b0, 1, 4, 200, 34);
        shot(1'b0, 50, 600, 1'b1, 1, 4, 300, 51);

        for (int i = 0; i < 10; i++) begin
            shot(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, ARM_CYC + 40)),
                 int'($urandom_range(20, 1200)), 1'($urandom_range(0, 1)), 0, 0, 0, 0);
        end

        wait_cyc(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/echo_meas.md
Name: echo_meas

Overview:
- Consumes the periodic `trig` pulse driving the ultrasonic ranger, and the ranger's asynchronous `echo` return.
- Measures the echo high time in microseconds and converts it to distance in millimetres.
- Presents one result per trigger period with a single-cycle `valid` strobe, or a `timeout` strobe when no usable echo arrives.
- Sits between the trigger generator and the car's obstacle/steering logic.

Parameters:
- CLK_PER_US, 125, clock cycles per microsecond (125 MHz system clock).
- MAX_US, 38000, maximum accepted echo high time in us; reaching it means timeout.
- ARM_TO_US, 2000, maximum wait in us from trig falling edge to echo rising edge.
- K_MM, 11239, distance scale: dist_mm = (echo_us * K_MM) >> 16, i.e. 0.1715 mm/us.

Ports:
- clk      in   1   system clock, rising edge.
- rst_n    in   1   asynchronous active-low reset.
- trig     in   1   trigger pulse from the trigger generator; synchronous to clk.
- echo     in   1   ranger echo; asynchronous.
- echo_us  out  16  last valid echo width in us.
- dist_mm  out  16  last valid distance in mm.
- valid    out  1   one-cycle strobe; echo_us/dist_mm updated this cycle.
- timeout  out  1   one-cycle strobe; measurement aborted, data outputs unchanged.
- busy     out  1   high in every state except IDLE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs, counters, state and sync flops go to 0; state goes to IDLE.
  - Reset mid-measurement discards the measurement with no strobe.
- Echo input path:
  - echo passes through a 2-FF synchroniser to give echo_s; a further flop gives echo_d.
  - rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
- trig handling: registered once as trig_d; trig_fall = ~trig & trig_d.
- Prescaler `us_cnt` (0..CLK_PER_US-1):
  - Cleared on every state entry.
  - On reaching CLK_PER_US-1 it wraps and emits a 1-cycle tick.
- States and transitions:
  - IDLE: on trig_fall -> ARM.
  - ARM:
    - On rise -> MEAS, with echo_us counter = 0.
    - Else on tick, increment the wait counter; when the wait counter reaches ARM_TO_US -> pulse timeout, -> IDLE.
  - MEAS:
    - Each tick increments the width counter.
    - On fall -> CALC.
    - Else if the width counter reaches MAX_US -> pulse timeout, -> WAIT_LOW.
  - CALC:
    - Register product = width * K_MM (32-bit).
    - Next cycle -> DONE.
  - DONE:
    - echo_us <= width; dist_mm <= product[31:16] truncated to 16 bits; valid = 1 for exactly this cycle.
    - -> IDLE.
  - WAIT_LOW: stay until echo_s == 0, then -> IDLE, no strobe.
- Latency: valid is high in the 4th clk cycle after the first rising edge at which echo is sampled low: sync (2), CALC (1), DONE (1).
- Width resolution: floor(high_cycles / CLK_PER_US), ±1 us from synchroniser phase.
- Simultaneous and boundary events:
  - trig edges outside IDLE are ignored (no re-arm, no restart).
  - rise and tick in the same ARM cycle: rise wins.
  - fall in the same cycle the width counter reaches MAX_US: fall wins, result valid.
  - Echo already high on entering ARM is not a rise and is ignored until a fresh low->high edge.
- valid and timeout are never high together; at most one strobe per trigger.
- Arithmetic: unsigned only; no rounding.

Decomposition:
- Shared package `car_pkg`:
  - State enum: IDLE, ARM, MEAS, CALC, DONE, WAIT_LOW (3-bit).
  - Constants CLK_PER_US, K_MM, MAX_US, ARM_TO_US; the trigger generator reuses CLK_PER_US.
- Sub-module `echo_sync`:
  - Does the 2-FF synchroniser plus edge detect.
  - Outputs echo_s, rise, fall.
- The FSM, prescaler and multiply stay in echo_meas.

Test Plan:
- Reset: assert rst_n=0 mid-MEAS -> all outputs 0, busy=0; after release, no valid/timeout until the next trig.
- Nominal: trig pulse, echo rises 300 us after trig fall, held 125000 cycles (1000 us) -> valid once, echo_us=1000, dist_mm=171, valid 4 cycles after echo low.
- 1 m target: echo held 5831 us -> echo_us=5831, dist_mm=999.
- Missing echo: trig, echo stays 0 -> timeout pulse exactly ARM_TO_US=2000 us after trig fall, dist_mm/echo_us keep their previous values, busy drops the next cycle.
- Stuck echo: echo held high 40 ms -> timeout at 38000 us, busy stays high until echo low, then IDLE, no valid.
- Re-trigger/ignore: a second trig pulse during MEAS -> ignored, single valid for the original echo.
- Pre-high echo: echo already high at trig fall -> no measurement until a fresh rising edge.
